// File: rtl/d_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: Tuse/Tnew data-hazard detection
// plus a registered busy counter modelling the multi-cycle mult/div unit.
module d_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       PC_en,
    output logic       D_en,
    output logic       E_clr,
    output logic       md_busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rs_stall;
    logic          rt_stall;
    logic          md_stall;
    logic          stall;

    // Register 0 is hardwired, so it can never be a true dependency.
    assign rs_stall = (D_rs_addr != 5'd0) &&
                      (((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
                       ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse)));
    assign rt_stall = (D_rt_addr != 5'd0) &&
                      (((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
                       ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse)));
    assign md_stall = D_is_md && (md_busy || E_md_start);
    assign stall    = rs_stall | rt_stall | md_stall;

    // During reset the front end runs freely while E is kept flushed.
    assign PC_en = reset | ~stall;
    assign D_en  = reset | ~stall;
    assign E_clr = reset | stall;

    // A start while busy is dropped; md_stall keeps it from being issued.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt != '0)
            cnt_nxt = cnt - CW'(1);
        else if (E_md_start)
            cnt_nxt = E_md_is_div ? DIV_LD : MULT_LD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            md_busy <= (cnt_nxt != '0);
        end
    end

endmodule
